// File: rtl/sw_pkg.sv
// Shared types for the traceback / CIGAR stage.
// Arrow and op encodings, walker states, cell addressing.
package sw_pkg;

  localparam int TILE_DIM = 16;

  typedef enum logic [1:0] {
    AR_STOP = 2'b00,
    AR_DIAG = 2'b01,
    AR_UP   = 2'b10,
    AR_LEFT = 2'b11
  } arrow_e;

  typedef enum logic [1:0] {
    OP_M = 2'd0,
    OP_I = 2'd1,
    OP_D = 2'd2
  } cigar_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WALK,
    S_REQ,
    S_WAIT_TILE,
    S_FLUSH,
    S_DONE
  } state_e;

  // 2*(16r+c) is just {r,c,0}
  function automatic logic [8:0] cell_off(
    input logic [3:0] r,
    input logic [3:0] c
  );
    return {r, c, 1'b0};
  endfunction

endpackage

// File: rtl/cigar_builder_if.sv
// CIGAR op stream: valid/ready handshake.
// master drives ops, slave consumes them.
interface cigar_builder_if #(
  parameter int LEN_W = 10
);
  logic [1:0]       cigar_op;
  logic [LEN_W-1:0] cigar_len;
  logic             cigar_valid;
  logic             cigar_ready;

  modport master (
    output cigar_op, cigar_len, cigar_valid,
    input  cigar_ready
  );

  modport slave (
    input  cigar_op, cigar_len, cigar_valid,
    output cigar_ready
  );
endinterface

// File: rtl/cigar_run_encoder.sv
// Run-length accumulator plus the held output register.
// stall is high while an emitted op waits for ready.
module cigar_run_encoder
  import sw_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clear,
  input  logic             step,
  input  cigar_op_e        step_op,
  input  logic             flush,
  input  logic             ready,
  output logic             valid,
  output logic [1:0]       op,
  output logic [LEN_W-1:0] len,
  output logic             stall,
  output logic             run_open
);

  cigar_op_e        run_op;
  logic [LEN_W-1:0] run_len;
  logic             change;

  assign stall    = valid && !ready;
  assign run_open = run_len != '0;
  assign change   = run_open && step_op != run_op;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      valid   <= 1'b0;
      op      <= '0;
      len     <= '0;
      run_op  <= OP_M;
      run_len <= '0;
    end else if (clear) begin
      valid   <= 1'b0;
      op      <= '0;
      len     <= '0;
      run_op  <= OP_M;
      run_len <= '0;
    end else begin
      if (valid && ready)
        valid <= 1'b0;
      if (step) begin
        run_op <= step_op;
        if (change) begin
          valid   <= 1'b1;
          op      <= run_op;
          len     <= run_len;
          run_len <= LEN_W'(1);
        end else begin
          run_len <= run_len + LEN_W'(1);
        end
      end else if (flush && run_open) begin
        valid   <= 1'b1;
        op      <= run_op;
        len     <= run_len;
        run_len <= '0;
      end
    end
  end

endmodule

// File: rtl/cigar_builder.sv
// Traceback walker: follows arrows through 16x16 tiles,
// requests neighbour tiles, streams reverse CIGAR runs.
module cigar_builder
  import sw_pkg::*;
#(
  parameter int TILE_WAIT = 2,
  parameter int LEN_W     = 10
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic [511:0] arrow_matrix,
  input  logic [7:0]   start_pos,
  input  logic [3:0]   current_tile_row,
  input  logic [3:0]   current_tile_col,
  input  logic         cigar_valid_in,
  output logic         request_next_tile,
  output logic [3:0]   next_tile_row,
  output logic [3:0]   next_tile_col,
  output logic         cigar_done,
  cigar_builder_if.master cig
);

  localparam logic [7:0] WAIT_LIM =
    8'(TILE_WAIT > 1 ? TILE_WAIT - 1 : 0);

  state_e       state;
  logic [511:0] tile;
  logic [3:0]   r, c, trow, tcol;
  logic [7:0]   wait_cnt;
  arrow_e       arrow;
  cigar_op_e    step_op;
  logic         dr, dc, wrap_r, wrap_c, off_grid;
  logic         abort, stall, run_open;
  logic         walk_go, enc_step, enc_flush, tile_ok;

  assign arrow = arrow_e'(tile[cell_off(r, c) +: 2]);

  assign abort = !cigar_valid_in &&
    state inside {S_WALK, S_REQ, S_WAIT_TILE, S_FLUSH};

  assign walk_go   = state == S_WALK && !stall && !abort;
  assign enc_step  = walk_go && arrow != AR_STOP;
  assign enc_flush = state == S_FLUSH && !stall && !abort;

  assign wrap_r   = dr && r == '0;
  assign wrap_c   = dc && c == '0;
  assign off_grid = (wrap_r && trow == '0) ||
                    (wrap_c && tcol == '0);

  assign tile_ok = cigar_valid_in && wait_cnt >= WAIT_LIM &&
                   current_tile_row == next_tile_row &&
                   current_tile_col == next_tile_col;

  always_comb begin
    step_op = OP_M;
    dr      = 1'b0;
    dc      = 1'b0;
    unique case (1'b1)
      arrow == AR_DIAG: begin
        step_op = OP_M;
        dr      = 1'b1;
        dc      = 1'b1;
      end
      arrow == AR_UP: begin
        step_op = OP_I;
        dr      = 1'b1;
      end
      arrow == AR_LEFT: begin
        step_op = OP_D;
        dc      = 1'b1;
      end
      default: ;
    endcase
  end

  cigar_run_encoder #(.LEN_W(LEN_W)) u_enc (
    .clk      (clk),
    .resetN   (resetN),
    .clear    (abort),
    .step     (enc_step),
    .step_op  (step_op),
    .flush    (enc_flush),
    .ready    (cig.cigar_ready),
    .valid    (cig.cigar_valid),
    .op       (cig.cigar_op),
    .len      (cig.cigar_len),
    .stall    (stall),
    .run_open (run_open)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state             <= S_IDLE;
      tile              <= '0;
      r                 <= '0;
      c                 <= '0;
      trow              <= '0;
      tcol              <= '0;
      wait_cnt          <= '0;
      request_next_tile <= 1'b0;
      next_tile_row     <= '0;
      next_tile_col     <= '0;
      cigar_done        <= 1'b0;
    end else begin
      request_next_tile <= 1'b0;
      cigar_done        <= 1'b0;
      if (abort) begin
        state         <= S_IDLE;
        next_tile_row <= '0;
        next_tile_col <= '0;
      end else begin
        unique case (state)
          S_IDLE: if (cigar_valid_in) begin
            tile  <= arrow_matrix;
            r     <= start_pos[7:4];
            c     <= start_pos[3:0];
            trow  <= current_tile_row;
            tcol  <= current_tile_col;
            state <= S_WALK;
          end
          S_WALK: if (walk_go) begin
            if (arrow == AR_STOP) begin
              state <= S_FLUSH;
            end else begin
              // 4-bit wrap lands on 15 in the neighbour tile
              r <= r - {3'b0, dr};
              c <= c - {3'b0, dc};
              if (off_grid) begin
                state <= S_FLUSH;
              end else if (wrap_r || wrap_c) begin
                next_tile_row     <= trow - {3'b0, wrap_r};
                next_tile_col     <= tcol - {3'b0, wrap_c};
                request_next_tile <= 1'b1;
                state             <= S_REQ;
              end
            end
          end
          S_REQ: begin
            wait_cnt <= '0;
            state    <= S_WAIT_TILE;
          end
          S_WAIT_TILE: begin
            if (wait_cnt != 8'hFF)
              wait_cnt <= wait_cnt + 8'd1;
            if (tile_ok) begin
              tile          <= arrow_matrix;
              trow          <= next_tile_row;
              tcol          <= next_tile_col;
              next_tile_row <= '0;
              next_tile_col <= '0;
              state         <= S_WALK;
            end
          end
          S_FLUSH: if (!stall && !run_open) begin
            state      <= S_DONE;
            cigar_done <= 1'b1;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
